// File: rtl/cov_pkg.sv
// Shared constants and types for the covariance-matrix BRAM access path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cov_pkg;

  localparam int DATA_W      = 32;
  localparam int COV_ADDR_W  = 2;
  localparam int COV_DEPTH   = 4;
  localparam int BRAM_RD_LAT = 2;

  // One slot per read that can be outstanding at full throughput.
  localparam int FIFO_DEPTH  = BRAM_RD_LAT + 1;
  localparam int FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [COV_ADDR_W-1:0] index;
  } fifo_entry_t;

endpackage

// File: rtl/cov_rd_fifo.sv
// In-order FIFO holding returned BRAM words until the eigen stage takes them.
// Latency: a pushed entry is visible at head_dat the cycle after push.
// Backpressure: none of its own; the issuer's credit rule keeps pushes within capacity.
//
// Ports: clk/rst_n (async active-low), push + push_dat, pop, head_dat (oldest entry),
//        count (number of valid entries).
module cov_rd_fifo
  import cov_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  fifo_entry_t           push_dat,
  input  logic                  pop,
  output fifo_entry_t           head_dat,
  output logic [FIFO_CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  fifo_entry_t      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop   = pop && (count != '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push  = push && ((count != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + FIFO_CNT_W'(1);
        2'b01:   count <= count - FIFO_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cov_bram_ctrl.sv
// Arbitrates the covariance BRAM port between engine writes and an in-order read sweep.
// Latency: rd_start in T -> first beat in T+4, one beat/cycle, done pulse after last beat.
// Backpressure: rd_ready low stalls the head beat; read issue is credit-limited so no word is lost.
//
// Ports: wr_valid/wr_ready/wr_addr/wr_data  engine write channel (IDLE only)
//        rd_start/busy/done                 sweep control and status
//        rd_valid/rd_ready/rd_data/rd_index/rd_last  output stream to eigen stage
//        bram_ena/bram_wea/bram_addra/bram_dina/bram_douta  single-port BRAM interface
module cov_bram_ctrl #(
  parameter int DATA_W = cov_pkg::DATA_W,
  parameter int ADDR_W = cov_pkg::COV_ADDR_W,
  parameter int DEPTH  = cov_pkg::COV_DEPTH,
  parameter int RD_LAT = cov_pkg::BRAM_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_start,
  output logic              busy,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_index,
  output logic              rd_last,
  output logic              done,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  input  logic [DATA_W-1:0] bram_douta
);

  import cov_pkg::*;

  localparam logic [ADDR_W:0]   ISSUE_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  state_t                  state;
  logic [ADDR_W:0]         issued;       // one extra bit so it can reach DEPTH
  logic [RD_LAT-1:0]       vld_sr;       // bit i set: a read issued i+1 cycles ago
  logic [ADDR_W-1:0]       idx_sr [RD_LAT];
  logic                    wr_fire;
  logic                    issue;
  logic                    pop;
  int                      inflight;
  int                      credit_used;
  fifo_entry_t             push_dat;
  fifo_entry_t             head_dat;
  logic [FIFO_CNT_W-1:0]   fifo_count;

  // Reads on the way back plus words parked in the FIFO must fit in the FIFO;
  // a pop in this cycle frees a slot in time for the next return.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + int'(vld_sr[i]);
    end
    credit_used = inflight + int'(fifo_count) - int'(pop);
  end

  assign wr_ready = (state == IDLE) && !rd_start;
  assign wr_fire  = wr_valid && wr_ready;
  assign issue    = (state == READ) && (issued < ISSUE_MAX) && (credit_used < RD_LAT + 1);

  // Writes and read issue never overlap: writes need IDLE, issue needs READ.
  assign bram_ena   = wr_fire || issue;
  assign bram_wea   = wr_fire;
  assign bram_addra = wr_fire ? wr_addr : issued[ADDR_W-1:0];
  assign bram_dina  = wr_fire ? wr_data : '0;

  assign rd_valid = (fifo_count != '0);
  assign rd_data  = rd_valid ? head_dat.data  : '0;
  assign rd_index = rd_valid ? head_dat.index : '0;
  assign rd_last  = rd_valid && (head_dat.index == LAST_IDX);
  assign pop      = rd_valid && rd_ready;
  assign busy     = (state == READ);

  assign push_dat = '{data: bram_douta, index: idx_sr[RD_LAT-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      issued <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_start) begin
            state  <= READ;
            issued <= '0;
          end
        end
        READ: begin
          if (issue) begin
            issued <= issued + (ADDR_W + 1)'(1);
          end
          if (pop && rd_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tracks each issued read until its word appears on bram_douta.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        idx_sr[i] <= '0;
      end
    end else begin
      vld_sr[0] <= issue;
      idx_sr[0] <= issued[ADDR_W-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        idx_sr[i] <= idx_sr[i-1];
      end
    end
  end

  cov_rd_fifo u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (vld_sr[RD_LAT-1]),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_cov_bram_ctrl.sv
`timescale 1ns/1ps
module tb_cov_bram_ctrl;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_start = 1'b0;
  logic          busy;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_index;
  logic          rd_last;
  logic          done;
  logic          bram_ena;
  logic          bram_wea;
  logic [AW-1:0] bram_addra;
  logic [DW-1:0] bram_dina;
  logic [DW-1:0] bram_douta = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cov_bram_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_start   (rd_start),
    .busy       (busy),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_index   (rd_index),
    .rd_last    (rd_last),
    .done       (done),
    .bram_ena   (bram_ena),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_douta (bram_douta)
  );

  // Single-port BRAM, 2-cycle read latency.
  logic [DW-1:0] bram_mem [N];
  logic [DW-1:0] bram_p1 = '0;
  always @(posedge clk) begin
    if (bram_ena && bram_wea) bram_mem[bram_addra] <= bram_dina;
    if (bram_ena && !bram_wea) bram_p1 <= bram_mem[bram_addra];
    bram_douta <= bram_p1;
  end

  // Reference: matrix contents as the engine has written them.
  logic [DW-1:0] model_mem [N];

  // Sweep observation record.
  logic [DW-1:0] got_data [$];
  logic [AW-1:0] got_idx  [$];
  logic          got_last [$];
  int  done_cnt, issue_cnt, pop_cnt, max_out, stall_viol;
  bit  timed_out;

  // rdy_mode: 0 always ready, 1 random, 2 never ready. Stops 3 cycles after done.
  task automatic collect(input int max_cyc, input int rdy_mode);
    logic          held_vld;
    logic [DW-1:0] held_data;
    logic [AW-1:0] held_idx;
    int            after_done;
    got_data.delete(); got_idx.delete(); got_last.delete();
    done_cnt = 0; issue_cnt = 0; pop_cnt = 0; max_out = 0; stall_viol = 0;
    timed_out = 1'b0; held_vld = 1'b0; held_data = '0; held_idx = '0; after_done = -1;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      rd_start = 1'b0;
      rd_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (held_vld && (!rd_valid || rd_data !== held_data || rd_index !== held_idx)) stall_viol++;
      if (bram_ena && !bram_wea) issue_cnt++;
      if (rd_valid && rd_ready) begin
        got_data.push_back(rd_data);
        got_idx.push_back(rd_index);
        got_last.push_back(rd_last);
        pop_cnt++;
      end
      if (issue_cnt - pop_cnt > max_out) max_out = issue_cnt - pop_cnt;
      held_vld = rd_valid && !rd_ready; held_data = rd_data; held_idx = rd_index;
      if (done) done_cnt++;
      if (after_done >= 0) after_done++;
      else if (done) after_done = 0;
      if (after_done >= 3) return;
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    logic [39:0] obs;
    #2;
    obs = {busy, rd_valid, rd_last, done, bram_ena, bram_wea, rd_index, rd_data};
    n_checks++;
    if (obs !== 40'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 40'h0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wr_ready, busy, rd_valid} !== 3'b100) begin
      n_fail++; $display("FAIL reset_release: got %b expected %b", {wr_ready, busy, rd_valid}, 3'b100);
    end
  endtask

  task automatic test_writes();
    logic [DW-1:0] pat [N];
    logic [36:0]   obs, exp;
    pat[0] = 32'h11111111; pat[1] = 32'h22222222; pat[2] = 32'h33333333; pat[3] = 32'h44444444;
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = pat[i];
      @(negedge clk);
      obs = {wr_ready, bram_ena, bram_wea, bram_addra, bram_dina};
      exp = {3'b111, AW'(i), pat[i]};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL write_%0d: got %h expected %h", i, obs, exp);
      end
      model_mem[i] = pat[i];
    end
    @(posedge clk); #1; wr_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bram_ena !== 1'b0) begin
      n_fail++; $display("FAIL write_idle_ena: got %b expected 0", bram_ena);
    end
  endtask

  // Exact cycle-by-cycle timing of an unstalled sweep.
  task automatic test_sweep();
    logic [41:0] obs, exp;
    bit          e_busy, e_vld, e_last, e_done, e_ena;
    @(posedge clk); #1; rd_start = 1'b1; rd_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wr_ready, busy, bram_ena} !== 3'b000) begin
      n_fail++; $display("FAIL sweep_start: got %b expected 000", {wr_ready, busy, bram_ena});
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1; rd_start = 1'b0;
      @(negedge clk);
      e_busy = (k <= 7); e_vld = (k >= 4 && k <= 7); e_last = (k == 7);
      e_done = (k == 8); e_ena = (k <= 4);
      obs = {busy, rd_valid, rd_last, done, bram_ena, bram_wea,
             (bram_ena ? bram_addra : 2'b00), rd_index, rd_data};
      exp = {e_busy, e_vld, e_last, e_done, e_ena, 1'b0,
             (e_ena ? AW'(k - 1) : 2'b00),
             (e_vld ? AW'(k - 4) : 2'b00),
             (e_vld ? model_mem[k - 4] : 32'h0)};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL sweep_T+%0d: got %h expected %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    int first_issues;
    @(posedge clk); #1; rd_start = 1'b1; rd_ready = 1'b0;
    collect(8, 2);
    first_issues = issue_cnt;
    n_checks++;
    if (issue_cnt > 3 || issue_cnt == 0 || pop_cnt != 0 || stall_viol != 0) begin
      n_fail++;
      $display("FAIL bp_stall: got issues=%0d pops=%0d stall_viol=%0d expected issues 1..3 pops=0 viol=0",
               issue_cnt, pop_cnt, stall_viol);
    end
    n_checks++;
    if ({rd_valid, rd_index, rd_data} !== {1'b1, 2'b00, model_mem[0]}) begin
      n_fail++;
      $display("FAIL bp_head: got %h expected %h", {rd_valid, rd_index, rd_data}, {1'b1, 2'b00, model_mem[0]});
    end
    collect(30, 0);
    n_checks++;
    if (timed_out || done_cnt != 1 || first_issues + issue_cnt != N) begin
      n_fail++;
      $display("FAIL bp_release: got timeout=%0d done=%0d issues=%0d expected 0/1/%0d",
               timed_out, done_cnt, first_issues + issue_cnt, N);
    end
    n_checks++;
    if (got_data.size() != N) begin
      n_fail++; $display("FAIL bp_beats: got %0d expected %0d", got_data.size(), N);
    end
    for (int i = 0; i < got_data.size() && i < N; i++) begin
      n_checks++;
      if ({got_idx[i], got_last[i], got_data[i]} !== {AW'(i), (i == N - 1), model_mem[i]}) begin
        n_fail++;
        $display("FAIL bp_beat_%0d: got %h expected %h", i,
                 {got_idx[i], got_last[i], got_data[i]}, {AW'(i), (i == N - 1), model_mem[i]});
      end
    end
  endtask

  task automatic test_conflict();
    @(posedge clk); #1;
    rd_start = 1'b1; rd_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if ({wr_ready, bram_ena, bram_wea} !== 3'b000) begin
      n_fail++; $display("FAIL conflict_same_cycle: got %b expected 000", {wr_ready, bram_ena, bram_wea});
    end
    @(posedge clk); #1; rd_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({wr_ready, bram_wea, busy} !== 3'b001) begin
      n_fail++; $display("FAIL conflict_write_in_read: got %b expected 001", {wr_ready, bram_wea, busy});
    end
    @(posedge clk); #1; rd_start = 1'b1; wr_valid = 1'b0;
    @(negedge clk);
    collect(30, 0);
    n_checks++;
    if (timed_out || done_cnt != 1 || got_data.size() != N) begin
      n_fail++;
      $display("FAIL conflict_sweep: got timeout=%0d done=%0d beats=%0d expected 0/1/%0d",
               timed_out, done_cnt, got_data.size(), N);
    end
    for (int i = 0; i < got_data.size() && i < N; i++) begin
      n_checks++;
      if ({got_idx[i], got_last[i], got_data[i]} !== {AW'(i), (i == N - 1), model_mem[i]}) begin
        n_fail++;
        $display("FAIL conflict_beat_%0d: got %h expected %h", i,
                 {got_idx[i], got_last[i], got_data[i]}, {AW'(i), (i == N - 1), model_mem[i]});
      end
    end
    n_checks++;
    if (got_data.size() > 1 && got_data[1] !== 32'h22222222) begin
      n_fail++; $display("FAIL conflict_idx1: got %h expected 22222222", got_data[1]);
    end
  endtask

  task automatic test_read_after_write();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'($urandom_range(0, N - 1)); d = $urandom;
    @(posedge clk); #1; wr_valid = 1'b1; wr_addr = a; wr_data = d; rd_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wr_ready, bram_wea, bram_addra, bram_dina} !== {2'b11, a, d}) begin
      n_fail++;
      $display("FAIL raw_write: got %h expected %h", {wr_ready, bram_wea, bram_addra, bram_dina}, {2'b11, a, d});
    end
    model_mem[a] = d;
    @(posedge clk); #1; wr_valid = 1'b0; rd_start = 1'b1;
    collect(30, 0);
    n_checks++;
    if (timed_out || got_data.size() != N) begin
      n_fail++; $display("FAIL raw_sweep: got timeout=%0d beats=%0d expected 0/%0d", timed_out, got_data.size(), N);
    end
    for (int i = 0; i < got_data.size() && i < N; i++) begin
      n_checks++;
      if ({got_idx[i], got_data[i]} !== {AW'(i), model_mem[i]}) begin
        n_fail++;
        $display("FAIL raw_beat_%0d: got %h expected %h", i, {got_idx[i], got_data[i]}, {AW'(i), model_mem[i]});
      end
    end
  endtask

  task automatic test_random();
    int            nwr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int it = 0; it < 6; it++) begin
      nwr = $urandom_range(0, 6);
      for (int w = 0; w < nwr; w++) begin
        a = AW'($urandom_range(0, N - 1)); d = $urandom;
        @(posedge clk); #1;
        wr_valid = 1'($urandom_range(0, 1)); wr_addr = a; wr_data = d;
        @(negedge clk);
        if (wr_valid) begin
          n_checks++;
          if ({wr_ready, bram_ena, bram_wea, bram_addra, bram_dina} !== {3'b111, a, d}) begin
            n_fail++;
            $display("FAIL rnd_write_%0d_%0d: got %h expected %h", it, w,
                     {wr_ready, bram_ena, bram_wea, bram_addra, bram_dina}, {3'b111, a, d});
          end
          model_mem[a] = d;
        end
      end
      @(posedge clk); #1; wr_valid = 1'b0; rd_start = 1'b1;
      collect(80, 1);
      n_checks++;
      if (timed_out || done_cnt != 1 || issue_cnt != N || max_out > 3 || stall_viol != 0) begin
        n_fail++;
        $display("FAIL rnd_sweep_%0d: got to=%0d done=%0d issues=%0d max_out=%0d viol=%0d expected 0/1/%0d/<=3/0",
                 it, timed_out, done_cnt, issue_cnt, max_out, stall_viol, N);
      end
      n_checks++;
      if (got_data.size() != N) begin
        n_fail++; $display("FAIL rnd_beats_%0d: got %0d expected %0d", it, got_data.size(), N);
      end
      for (int i = 0; i < got_data.size() && i < N; i++) begin
        n_checks++;
        if ({got_idx[i], got_last[i], got_data[i]} !== {AW'(i), (i == N - 1), model_mem[i]}) begin
          n_fail++;
          $display("FAIL rnd_beat_%0d_%0d: got %h expected %h", it, i,
                   {got_idx[i], got_last[i], got_data[i]}, {AW'(i), (i == N - 1), model_mem[i]});
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int          beats;
    logic [40:0] obs;
    beats = 0;
    @(posedge clk); #1; rd_start = 1'b1; rd_ready = 1'b1;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      @(posedge clk); #1; rd_start = 1'b0;
      @(negedge clk);
      if (rd_valid && rd_ready) beats++;
    end
    n_checks++;
    if (beats != 2) begin
      n_fail++; $display("FAIL midrst_two_beats: got %0d expected 2", beats);
    end
    @(posedge clk); #3; rst_n = 1'b0; #1;
    obs = {wr_ready, busy, rd_valid, rd_last, done, bram_ena, bram_wea, rd_index, rd_data};
    n_checks++;
    if (obs !== {1'b1, 40'h0}) begin
      n_fail++; $display("FAIL midrst_outputs: got %h expected %h", obs, {1'b1, 40'h0});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; rd_start = 1'b1;
    collect(30, 0);
    n_checks++;
    if (timed_out || done_cnt != 1 || issue_cnt != N || got_data.size() != N) begin
      n_fail++;
      $display("FAIL midrst_restart: got to=%0d done=%0d issues=%0d beats=%0d expected 0/1/%0d/%0d",
               timed_out, done_cnt, issue_cnt, got_data.size(), N, N);
    end
    for (int i = 0; i < got_data.size() && i < N; i++) begin
      n_checks++;
      if ({got_idx[i], got_last[i], got_data[i]} !== {AW'(i), (i == N - 1), model_mem[i]}) begin
        n_fail++;
        $display("FAIL midrst_beat_%0d: got %h expected %h", i,
                 {got_idx[i], got_last[i], got_data[i]}, {AW'(i), (i == N - 1), model_mem[i]});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      bram_mem[i]  = '0;
      model_mem[i] = '0;
    end
    test_reset();
    test_writes();
    test_sweep();
    test_backpressure();
    test_conflict();
    test_read_after_write();
    test_random();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cov_bram_ctrl.md
Name: cov_bram_ctrl

Overview:
Access controller that sits between the covariance compute engine and the covariance-matrix BRAM (single-port, 32-bit, 4 entries, 2-cycle read latency). It arbitrates the BRAM port between engine writes (valid/ready) and a read sweep. A read sweep streams all entries out in address order on a valid/ready interface toward the eigen stage. It hides the BRAM read latency with credit-based issue and a small output FIFO, so backpressure never loses data.

Parameters:
DATA_W, 32, BRAM word width
ADDR_W, 2, BRAM address width
DEPTH, 4, entries per sweep (2x2 covariance matrix)
RD_LAT, 2, BRAM read latency in cycles (ena/addr cycle to douta valid)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, asynchronous, active-low
wr_valid  in  1  engine write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_start  in  1  one-cycle pulse, start read sweep
busy  out  1  sweep in progress
rd_valid  out  1  output beat valid
rd_ready  in  1  downstream ready
rd_data  out  DATA_W  matrix element
rd_index  out  ADDR_W  address of rd_data
rd_last  out  1  marks beat index DEPTH-1
done  out  1  one-cycle pulse after last beat handshake
bram_ena  out  1  to BRAM ena
bram_wea  out  1  to BRAM wea
bram_addra  out  ADDR_W  to BRAM addra
bram_dina  out  DATA_W  to BRAM dina
bram_douta  in  DATA_W  from BRAM douta

Behaviour:
- Reset (async, rst_n=0): state IDLE, issue counter, in-flight shift register and FIFO cleared. busy, rd_valid, rd_last, done, rd_data, rd_index all 0. bram_ena/bram_wea are 0.
- FSM: IDLE -> READ on rd_start. READ -> IDLE on the handshake of the beat with rd_last=1. done pulses in the following cycle.
- wr_ready = (state==IDLE) && !rd_start. rd_start wins any same-cycle conflict.
- Write: on accept, in the same cycle (combinational), bram_ena=1, bram_wea=1, bram_addra=wr_addr, bram_dina=wr_data. Back-to-back writes run at 1/cycle.
- rd_start while busy is ignored. Writes are never accepted in READ.
- Read issue in READ: issue while issued<DEPTH and (inflight + fifo_count - pop_this_cycle) < RD_LAT+1.
- On issue: bram_ena=1, bram_wea=0, bram_addra=issued, then issued++.
- An RD_LAT-deep valid/index shift register tracks in-flight reads. bram_douta and its index are pushed into the FIFO in the cycle the shift register output is 1.
- FIFO: depth RD_LAT+1 (=3), in-order. Credit rule guarantees no overflow, so no push is ever dropped.
- rd_valid = FIFO non-empty. rd_data, rd_index and rd_last come from the FIFO head. rd_last = (rd_index==DEPTH-1). Beats hold stable while rd_valid && !rd_ready.
- Timing with rd_start in cycle T and rd_ready=1: issues in T+1..T+4, rd_valid from T+4, beats 0..3 in T+4..T+7, done in T+8, busy 1 in T+1..T+7. Full throughput of 1 beat/cycle.
- Read-after-write: a write accepted in cycle W is visible to a sweep started in W+1.
- Reset mid-sweep: everything aborts immediately to reset values. The next rd_start restarts at index 0.
- Index arithmetic is modulo 2^ADDR_W. issued is ADDR_W+1 bits wide, so it can reach DEPTH.

Decomposition:
- Shared package cov_pkg: DATA_W, COV_ADDR_W, COV_DEPTH, BRAM_RD_LAT constants; FSM state enum (IDLE, READ); FIFO entry struct {data, index}.
- One sub-module, cov_rd_fifo: 3-entry synchronous FIFO with push/pop, count output and async active-low reset.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately; after release with rd_start=0, wr_ready=1.
- Writes: wr_valid on 4 consecutive cycles, addr 0..3, data 0x11111111/0x22222222/0x33333333/0x44444444 -> bram_ena=bram_wea=1 for 4 cycles with matching addra/dina, wr_ready stays 1.
- Sweep with rd_ready=1: rd_start at T -> rd_data 0x11111111..0x44444444 and rd_index 0..3 in T+4..T+7, rd_last only at T+7, done at T+8, busy low at T+8.
- Backpressure: rd_ready=0 for 8 cycles after rd_start -> at most 3 reads issued, rd_valid held with rd_data=0x11111111 stable. Releasing rd_ready yields all 4 beats in order with no loss or duplicate.
- Conflict: rd_start and wr_valid (addr 1, 0xDEADBEEF) in the same cycle -> wr_ready=0, no BRAM write, and the sweep returns 0x22222222 at index 1. A second rd_start during busy is ignored (one done only).
- Reset mid-sweep after 2 beats -> outputs zeroed, FSM IDLE. A new rd_start returns indices 0..3 from the start.
